ov5640_dvp_capture: RTL and testbench

Pixel-capture stage directly downstream of the OV5640 setup/SCCB configuration path. Once configuration has finished (`capture_enable`, driven from the SCCB send-finish output), the block samples the sensor's 8-bit DVP bus and assembles byte pairs into RGB565 pixels. It emits a single-cycle pixel strobe with frame/line markers and checks every line and frame against the configured geometry. It sits between the camera pins and the frame-buffer writer.

---
 rtl/ov5640_dvp_capture.sv | 232 +++++++++++++++++++++++
 tb/tb_ov5640_dvp_capture.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ov5640_dvp_capture.sv
// OV5640 DVP capture: oversamples the raw sensor bus in the sys_clk domain,
// pairs bytes into RGB565 pixels and checks line/frame geometry.
module ov5640_dvp_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cam_pclk,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        capture_enable,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);

    localparam int BW = $clog2(2*H_ACTIVE+2);
    localparam int PW = $clog2(H_ACTIVE+1);
    localparam int LW = $clog2(V_ACTIVE+2);

    localparam logic [BW-1:0] BYTE_FULL = BW'(2*H_ACTIVE);
    localparam logic [BW-1:0] BYTE_SAT  = BW'(2*H_ACTIVE+1);
    localparam logic [PW-1:0] PIX_FULL  = PW'(H_ACTIVE);
    localparam logic [PW-1:0] PIX_LAST  = PW'(H_ACTIVE-1);
    localparam logic [LW-1:0] LINE_FULL = LW'(V_ACTIVE);
    localparam logic [LW-1:0] LINE_SAT  = LW'(V_ACTIVE+1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_VS,
        ST_ACTIVE
    } state_t;

    state_t r_state;

    logic       r_pclk_s1, r_pclk_s2, r_pclk_s3;
    logic       r_href_s1, r_href_s2, r_href_s3;
    logic       r_vs_s1,   r_vs_s2,   r_vs_s3;
    logic [7:0] r_data_s1, r_data_s2;

    logic       w_pclk_rise, w_href_fall, w_vs_rise, w_vs_fall;

    logic       r_ev1_rise, r_ev1_href, r_ev1_hfall, r_ev1_vrise, r_ev1_vfall;
    logic [7:0] r_ev1_data;
    logic       r_ev2_rise, r_ev2_href, r_ev2_hfall, r_ev2_vrise, r_ev2_vfall;
    logic [7:0] r_ev2_data;

    logic [BW-1:0] r_byte_cnt;
    logic [PW-1:0] r_pix_cnt;
    logic [LW-1:0] r_line_cnt;
    logic          r_phase;
    logic [7:0]    r_hi_byte;
    logic          r_sof_pend;

    logic [15:0] r_pix_data;
    logic        r_pix_valid, r_pix_sof, r_pix_eol;
    logic        r_frame_done, r_line_err, r_frame_err;
    logic [15:0] r_frame_cnt;

    logic [LW-1:0] w_line_inc;
    logic [LW-1:0] w_lines_at_end;
    logic          w_pix_ok;

    assign w_pclk_rise = r_pclk_s2 & ~r_pclk_s3;
    assign w_href_fall = ~r_href_s2 & r_href_s3;
    assign w_vs_rise   = r_vs_s2 & ~r_vs_s3;
    assign w_vs_fall   = ~r_vs_s2 & r_vs_s3;

    assign w_line_inc     = (r_line_cnt == LINE_SAT) ? r_line_cnt : r_line_cnt + 1'b1;
    assign w_lines_at_end = r_ev2_hfall ? w_line_inc : r_line_cnt;
    assign w_pix_ok       = (r_pix_cnt < PIX_FULL) && (r_line_cnt < LINE_FULL);

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_pclk_s1 <= 1'b0;
            r_pclk_s2 <= 1'b0;
            r_pclk_s3 <= 1'b0;
            r_href_s1 <= 1'b0;
            r_href_s2 <= 1'b0;
            r_href_s3 <= 1'b0;
            r_vs_s1   <= 1'b0;
            r_vs_s2   <= 1'b0;
            r_vs_s3   <= 1'b0;
            r_data_s1 <= '0;
            r_data_s2 <= '0;
        end else begin
            r_pclk_s1 <= cam_pclk;
            r_pclk_s2 <= r_pclk_s1;
            r_pclk_s3 <= r_pclk_s2;
            r_href_s1 <= cam_href;
            r_href_s2 <= r_href_s1;
            r_href_s3 <= r_href_s2;
            r_vs_s1   <= cam_vsync;
            r_vs_s2   <= r_vs_s1;
            r_vs_s3   <= r_vs_s2;
            r_data_s1 <= cam_data;
            r_data_s2 <= r_data_s1;
        end
    end

    // Two alignment stages so every registered output lands exactly four
    // sys_clk edges after the raw input edge is first sampled.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_ev1_rise  <= 1'b0;
            r_ev1_href  <= 1'b0;
            r_ev1_hfall <= 1'b0;
            r_ev1_vrise <= 1'b0;
            r_ev1_vfall <= 1'b0;
            r_ev1_data  <= '0;
            r_ev2_rise  <= 1'b0;
            r_ev2_href  <= 1'b0;
            r_ev2_hfall <= 1'b0;
            r_ev2_vrise <= 1'b0;
            r_ev2_vfall <= 1'b0;
            r_ev2_data  <= '0;
        end else begin
            r_ev1_rise  <= w_pclk_rise;
            r_ev1_href  <= r_href_s2;
            r_ev1_hfall <= w_href_fall;
            r_ev1_vrise <= w_vs_rise;
            r_ev1_vfall <= w_vs_fall;
            r_ev1_data  <= r_data_s2;
            r_ev2_rise  <= r_ev1_rise;
            r_ev2_href  <= r_ev1_href;
            r_ev2_hfall <= r_ev1_hfall;
            r_ev2_vrise <= r_ev1_vrise;
            r_ev2_vfall <= r_ev1_vfall;
            r_ev2_data  <= r_ev1_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state      <= ST_IDLE;
            r_byte_cnt   <= '0;
            r_pix_cnt    <= '0;
            r_line_cnt   <= '0;
            r_phase      <= 1'b0;
            r_hi_byte    <= '0;
            r_sof_pend   <= 1'b0;
            r_pix_data   <= '0;
            r_pix_valid  <= 1'b0;
            r_pix_sof    <= 1'b0;
            r_pix_eol    <= 1'b0;
            r_frame_done <= 1'b0;
            r_line_err   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_pix_valid  <= 1'b0;
            r_pix_sof    <= 1'b0;
            r_pix_eol    <= 1'b0;
            r_frame_done <= 1'b0;
            r_line_err   <= 1'b0;
            r_frame_err  <= 1'b0;
            if (!capture_enable) begin
                r_state    <= ST_IDLE;
                r_phase    <= 1'b0;
                r_byte_cnt <= '0;
                r_pix_cnt  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_WAIT_VS;
                    ST_WAIT_VS: begin
                        if (r_ev2_vfall) begin
                            r_line_cnt <= '0;
                            r_byte_cnt <= '0;
                            r_pix_cnt  <= '0;
                            r_phase    <= 1'b0;
                            r_sof_pend <= 1'b1;
                            r_state    <= ST_ACTIVE;
                        end
                    end
                    ST_ACTIVE: begin
                        if (r_ev2_rise && r_ev2_href) begin
                            if (r_byte_cnt != BYTE_SAT)
                                r_byte_cnt <= r_byte_cnt + 1'b1;
                            if (!r_phase) begin
                                r_hi_byte <= r_ev2_data;
                                r_phase   <= 1'b1;
                            end else begin
                                r_phase <= 1'b0;
                                if (r_pix_cnt != PIX_FULL)
                                    r_pix_cnt <= r_pix_cnt + 1'b1;
                                if (w_pix_ok) begin
                                    r_pix_data  <= {r_hi_byte, r_ev2_data};
                                    r_pix_valid <= 1'b1;
                                    r_pix_sof   <= r_sof_pend;
                                    r_pix_eol   <= (r_pix_cnt == PIX_LAST);
                                    r_sof_pend  <= 1'b0;
                                end
                            end
                        end
                        // A falling HREF drops any dangling odd byte with the phase reset.
                        if (r_ev2_hfall) begin
                            r_line_err <= (r_byte_cnt != BYTE_FULL);
                            r_line_cnt <= w_line_inc;
                            r_byte_cnt <= '0;
                            r_pix_cnt  <= '0;
                            r_phase    <= 1'b0;
                        end
                        if (r_ev2_vrise) begin
                            r_frame_done <= 1'b1;
                            r_frame_cnt  <= r_frame_cnt + 1'b1;
                            r_frame_err  <= (w_lines_at_end != LINE_FULL);
                            r_state      <= ST_WAIT_VS;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign pix_data   = r_pix_data;
    assign pix_valid  = r_pix_valid;
    assign pix_sof    = r_pix_sof;
    assign pix_eol    = r_pix_eol;
    assign frame_done = r_frame_done;
    assign line_err   = r_line_err;
    assign frame_err  = r_frame_err;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_ov5640_dvp_capture.sv
// Directed bench for ov5640_dvp_capture with H_ACTIVE=4, V_ACTIVE=2 and
// cam_pclk at a quarter of sys_clk.
module tb_ov5640_dvp_capture;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        cam_pclk = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = '0;
    logic        capture_enable = 1'b0;
    logic [15:0] pix_data;
    logic        pix_valid, pix_sof, pix_eol;
    logic        frame_done, line_err, frame_err;
    logic [15:0] frame_cnt;

    ov5640_dvp_capture #(.H_ACTIVE(4), .V_ACTIVE(2)) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .cam_pclk       (cam_pclk),
        .cam_vsync      (cam_vsync),
        .cam_href       (cam_href),
        .cam_data       (cam_data),
        .capture_enable (capture_enable),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .pix_sof        (pix_sof),
        .pix_eol        (pix_eol),
        .frame_done     (frame_done),
        .line_err       (line_err),
        .frame_err      (frame_err),
        .frame_cnt      (frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc++;

    // Output monitor, sampled on the falling edge.
    int          n_valid = 0, n_sof = 0, n_eol = 0, n_lerr = 0, n_ferr = 0, n_fdone = 0;
    int          n_b2b = 0, lerr_cyc = 0;
    logic        prev_valid = 1'b0;
    logic [15:0] data_log [256];
    logic        sof_log  [256];
    logic        eol_log  [256];
    int          vcyc_log [256];

    always @(negedge sys_clk) begin
        if (pix_valid) begin
            data_log[n_valid % 256] = pix_data;
            sof_log[n_valid % 256]  = pix_sof;
            eol_log[n_valid % 256]  = pix_eol;
            vcyc_log[n_valid % 256] = cyc;
            n_valid++;
            if (prev_valid) n_b2b++;
        end
        if (pix_sof)    n_sof++;
        if (pix_eol)    n_eol++;
        if (frame_done) n_fdone++;
        if (frame_err)  n_ferr++;
        if (line_err) begin
            n_lerr++;
            lerr_cyc = cyc;
        end
        prev_valid = pix_valid;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int rise_edge = 0, fall_edge = 0, line_rise2 = 0;

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge sys_clk);
        cam_pclk = 1'b0;
        cam_data = b;
        cam_href = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        cam_pclk  = 1'b1;
        rise_edge = cyc + 1;
        @(negedge sys_clk);
    endtask

    task automatic send_bytes(input int n, input int first);
        for (int k = 0; k < n; k++) begin
            send_byte(8'((first + k + 1) * 17));
            if (k == 1) line_rise2 = rise_edge;
        end
    endtask

    task automatic end_line();
        @(negedge sys_clk);
        cam_pclk  = 1'b0;
        cam_href  = 1'b0;
        fall_edge = cyc + 1;
        wait_cycles(8);
    endtask

    task automatic send_line(input int n, input int first);
        send_bytes(n, first);
        end_line();
    endtask

    task automatic vsync_pulse();
        @(negedge sys_clk);
        cam_vsync = 1'b1;
        wait_cycles(8);
        cam_vsync = 1'b0;
        wait_cycles(8);
    endtask

    int v0, s0, e0, l0, f0, d0, t0;

    task automatic snap();
        v0 = n_valid; s0 = n_sof; e0 = n_eol; l0 = n_lerr; f0 = n_ferr; d0 = n_fdone;
    endtask

    initial begin
        wait_cycles(3);
        check("reset_outputs", {pix_data, pix_valid, pix_sof, pix_eol, frame_done,
              line_err, frame_err, frame_cnt}, 64'd0);
        sys_rst = 1'b1;
        wait_cycles(2);
        capture_enable = 1'b1;
        wait_cycles(4);

        // 1: nominal frame
        vsync_pulse();
        snap();
        send_line(8, 0);
        t0 = line_rise2;
        send_line(8, 8);
        vsync_pulse();
        check("s1_strobes", n_valid - v0, 8);
        check("s1_first_data", data_log[v0 % 256], 16'h1122);
        check("s1_data5", data_log[(v0 + 4) % 256], 16'h99AA);
        check("s1_data8", data_log[(v0 + 7) % 256], 16'hFF10);
        check("s1_latency", vcyc_log[v0 % 256], t0 + 4);
        check("s1_sof", {sof_log[v0 % 256], 32'(n_sof - s0)}, {1'b1, 32'd1});
        check("s1_eol", {eol_log[(v0 + 3) % 256], eol_log[(v0 + 7) % 256],
              32'(n_eol - e0)}, {2'b11, 32'd2});
        check("s1_frame_done", n_fdone - d0, 1);
        check("s1_frame_cnt", frame_cnt, 16'd1);
        check("s1_errors", {32'(n_lerr - l0), 32'(n_ferr - f0)}, 64'd0);

        // 2: short line
        snap();
        send_line(6, 0);
        t0 = fall_edge;
        check("s2_short_strobes", n_valid - v0, 3);
        check("s2_short_eol", n_eol - e0, 0);
        check("s2_lerr", n_lerr - l0, 1);
        check("s2_lerr_latency", lerr_cyc, t0 + 4);
        send_line(8, 0);
        vsync_pulse();
        check("s2_total", {32'(n_valid - v0), 32'(n_eol - e0)}, {32'd7, 32'd1});
        check("s2_ferr", {32'(n_ferr - f0), 32'(n_fdone - d0)}, {32'd0, 32'd1});
        check("s2_frame_cnt", frame_cnt, 16'd2);

        // 3: three lines, last with 9 bytes
        snap();
        send_line(8, 0);
        send_line(8, 8);
        check("s3_two_lines", n_valid - v0, 8);
        send_line(9, 0);
        check("s3_third_line_strobes", n_valid - v0, 8);
        vsync_pulse();
        check("s3_errs", {32'(n_lerr - l0), 32'(n_ferr - f0)}, {32'd1, 32'd1});
        check("s3_frame_cnt", {frame_cnt, 32'(n_fdone - d0)}, {16'd3, 32'd1});

        // 4: enable during active line 1
        @(negedge sys_clk);
        capture_enable = 1'b0;
        wait_cycles(4);
        snap();
        vsync_pulse();
        send_bytes(3, 0);
        capture_enable = 1'b1;
        send_bytes(5, 3);
        end_line();
        send_line(8, 8);
        check("s4_no_strobes", n_valid - v0, 0);
        vsync_pulse();
        check("s4_no_done", n_fdone - d0, 0);
        send_line(8, 0);
        send_line(8, 8);
        vsync_pulse();
        check("s4_strobes", n_valid - v0, 8);
        check("s4_done", {frame_cnt, 32'(n_fdone - d0)}, {16'd4, 32'd1});

        // 5: abort after byte 3, then reset mid-line
        snap();
        send_bytes(3, 0);
        @(negedge sys_clk);
        capture_enable = 1'b0;
        send_bytes(5, 3);
        end_line();
        send_line(8, 8);
        vsync_pulse();
        check("s5_abort_strobes", n_valid - v0, 1);
        check("s5_abort_done", {frame_cnt, 32'(n_fdone - d0)}, {16'd4, 32'd0});
        capture_enable = 1'b1;
        vsync_pulse();
        send_line(8, 0);
        send_line(8, 8);
        vsync_pulse();
        send_bytes(4, 0);
        wait_cycles(8);
        check("s5_pre_reset", {pix_data, frame_cnt}, {16'h3344, 16'd5});
        @(negedge sys_clk);
        sys_rst  = 1'b0;
        cam_href = 1'b0;
        cam_pclk = 1'b0;
        #1;
        check("s5_reset_outputs", {pix_data, pix_valid, pix_sof, pix_eol, frame_done,
              line_err, frame_err, frame_cnt}, 64'd0);
        wait_cycles(3);
        sys_rst = 1'b1;
        wait_cycles(4);

        // 6: frame counter wrap
        @(negedge sys_clk);
        force dut.r_frame_cnt = 16'hFFFF;
        @(negedge sys_clk);
        release dut.r_frame_cnt;
        wait_cycles(2);
        check("s6_preload", frame_cnt, 16'hFFFF);
        snap();
        vsync_pulse();
        send_line(8, 0);
        send_line(8, 8);
        vsync_pulse();
        check("s6_wrap", {frame_cnt, 32'(n_fdone - d0)}, {16'h0000, 32'd1});
        check("s6_strobes", n_valid - v0, 8);

        check("no_back_to_back", n_b2b, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
